// File: rtl/sht21_seg_display_if.sv
// Link between the SHT21 computation stage and the display stage:
// BCD result, its valid strobe, and the temperature/humidity select.
interface sht21_seg_display_if;
    logic [15:0] displaydata;
    logic        data_valid;
    logic        com_sig;

    modport master (output displaydata, output data_valid, input  com_sig);
    modport slave  (input  displaydata, input  data_valid, output com_sig);
endinterface

// File: rtl/sht21_seg_display.sv
// 4-digit common-anode 7-segment driver for the SHT21 result (value x100).
// It also owns the free-running mode timer that selects temperature or humidity.
module sht21_seg_display #(
    parameter int SCAN_DIV   = 50000,
    parameter int MODE_TICKS = 100000000,
    parameter int BLANK_LEAD = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sht21_seg_display_if.slave        bus,
    output logic                      mode_led,
    output logic [3:0]                sel,
    output logic [7:0]                seg
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int MODE_W = $clog2(MODE_TICKS);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_TICKS - 1);

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [MODE_W-1:0] mode_cnt_q, mode_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       disp_q, disp_d;
    logic              valid_seen_q, valid_seen_d;
    logic              com_sig_q, com_sig_d;
    logic              mode_led_q, mode_led_d;
    logic [3:0]        sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        nib_s;

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hBF;
        endcase
    endfunction

    // Next-state logic for counters, capture and the registered display outputs
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            idx_d      = idx_q;
        end

        if (mode_cnt_q == MODE_LAST) begin
            mode_cnt_d = '0;
            com_sig_d  = ~com_sig_q;
        end else begin
            mode_cnt_d = mode_cnt_q + 1'b1;
            com_sig_d  = com_sig_q;
        end

        // mode_led latches the select as it was before any same-cycle toggle
        if (bus.data_valid) begin
            disp_d       = bus.displaydata;
            mode_led_d   = com_sig_q;
            valid_seen_d = 1'b1;
        end else begin
            disp_d       = disp_q;
            mode_led_d   = mode_led_q;
            valid_seen_d = valid_seen_q;
        end

        case (idx_q)
            2'd0:    nib_s = disp_q[3:0];
            2'd1:    nib_s = disp_q[7:4];
            2'd2:    nib_s = disp_q[11:8];
            2'd3:    nib_s = disp_q[15:12];
            default: nib_s = 4'hF;
        endcase

        sel_d = ~(4'b0001 << idx_q);
        if ((BLANK_LEAD != 0) && (idx_q == 2'd3) && (nib_s == 4'd0)) begin
            seg_d = 8'hFF;
        end else if ((idx_q == 2'd2) && valid_seen_q) begin
            seg_d = seg_code(nib_s) & 8'h7F;
        end else begin
            seg_d = seg_code(nib_s);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q   <= '0;
            mode_cnt_q   <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'hFFFF;
            valid_seen_q <= 1'b0;
            com_sig_q    <= 1'b1;
            mode_led_q   <= 1'b1;
            sel_q        <= 4'hF;
            seg_q        <= 8'hFF;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            mode_cnt_q   <= mode_cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            valid_seen_q <= valid_seen_d;
            com_sig_q    <= com_sig_d;
            mode_led_q   <= mode_led_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.com_sig = com_sig_q;
    assign mode_led    = mode_led_q;
    assign sel         = sel_q;
    assign seg         = seg_q;
endmodule

// File: tb/tb_sht21_seg_display.sv
// Scoreboard bench for sht21_seg_display: a cycle-count based reference model
// queues the expected outputs per clock, a monitor compares them on the falling edge.
module tb_sht21_seg_display;
    localparam int SD = 4;
    localparam int MT = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_led;
    logic [3:0] sel;
    logic [7:0] seg;

    sht21_seg_display_if u_if ();

    sht21_seg_display #(.SCAN_DIV(SD), .MODE_TICKS(MT), .BLANK_LEAD(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (u_if),
        .mode_led (mode_led),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       mode;
        logic       com;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   k     = 0;
    logic [15:0] m_disp  = 16'hFFFF;
    bit          m_valid = 1'b0;
    bit          m_mode  = 1'b1;
    bit          rst_seen = 1'b0;

    logic [7:0] seg_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    logic [3:0] sel_tbl [0:3]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [15:0] v);
        u_if.data_valid  = 1'b1;
        u_if.displaydata = v;
        @(negedge clk);
        u_if.data_valid  = 1'b0;
    endtask

    // Any reset pulse discards outstanding expectations
    initial forever begin
        @(negedge rst_n);
        rst_seen = 1'b1;
        exp_q.delete();
    end

    // Reference model: outputs after edge k follow from edge count and captured data
    initial begin : model
        int         slot;
        logic [3:0] nib;
        exp_t       e;
        forever begin
            @(posedge clk);
            if (!rst_n || rst_seen) begin
                k        = 0;
                m_disp   = 16'hFFFF;
                m_valid  = 1'b0;
                m_mode   = 1'b1;
                rst_seen = 1'b0;
            end
            if (rst_n) begin
                k++;
                slot  = ((k - 1) / SD) % 4;
                nib   = 4'((m_disp >> (4 * slot)) & 16'hF);
                e.sel = sel_tbl[slot];
                if (slot == 3 && nib == 4'd0)
                    e.seg = 8'hFF;
                else if (slot == 2 && m_valid)
                    e.seg = seg_tbl[nib] & 8'h7F;
                else
                    e.seg = seg_tbl[nib];
                e.com = ((k / MT) % 2) == 0;
                if (u_if.data_valid) begin
                    m_mode  = (((k - 1) / MT) % 2) == 0;
                    m_disp  = u_if.displaydata;
                    m_valid = 1'b1;
                end
                e.mode = m_mode;
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check("sel",      16'(sel),          16'(got.sel));
                check("seg",      16'(seg),          16'(got.seg));
                check("mode_led", 16'(mode_led),     16'(got.mode));
                check("com_sig",  16'(u_if.com_sig), 16'(got.com));
            end
        end
    end

    initial begin : stim
        int         guard;
        logic [15:0] v;
        u_if.data_valid  = 1'b0;
        u_if.displaydata = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_sel",  16'(sel),          16'h000F);
        check("rst_seg",  16'(seg),          16'h00FF);
        check("rst_com",  16'(u_if.com_sig), 16'h0001);
        check("rst_mode", 16'(mode_led),     16'h0001);
        rst_n = 1'b1;

        repeat (48) @(negedge clk);
        send(16'h2534);
        repeat (20) @(negedge clk);
        send(16'h0587);
        repeat (20) @(negedge clk);
        send(16'h1A09);
        repeat (20) @(negedge clk);

        // Capture on the very edge where com_sig falls 1->0
        guard = 0;
        while (!((((k + 1) % MT) == 0) && ((((k + 1) / MT) % 2) == 1)) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("toggle_wait_bound", 16'(guard < 100), 16'h0001);
        send(16'h9876);
        check("coinc_mode_led", 16'(mode_led),     16'h0001);
        check("coinc_com_sig",  16'(u_if.com_sig), 16'h0000);
        repeat (16) @(negedge clk);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom);
                1:       v = {4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9))};
                default: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            endcase
            send(v);
            repeat ($urandom_range(1, 18)) @(negedge clk);
        end

        // Asynchronous 3 ns reset pulse in the middle of a scan slot
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_sel",  16'(sel),          16'h000F);
        check("async_rst_seg",  16'(seg),          16'h00FF);
        check("async_rst_com",  16'(u_if.com_sig), 16'h0001);
        check("async_rst_mode", 16'(mode_led),     16'h0001);
        #2 rst_n = 1'b1;
        repeat (24) @(negedge clk);
        send(16'h0000);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
